// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-port arbiter/sequencer that owns the shared combinational
//                ALU. It grants one request, registers its operands, captures
//                the result and returns it with a valid/ready response.
//                Optional macro ALU_ARB_RR_EN selects round-robin arbitration
//                (fixed priority to requester 0 when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,

    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             busy,

    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_gnt;
    logic [OPW-1:0]     r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_zero;

    logic               w_pick1;
    logic               w_accept;
    logic               w_rsp_take;
    logic [OPW-1:0]     w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    // ------------------------------------------------------------------------
    // Arbitration: w_pick1 says requester 1 wins this IDLE cycle.
    // ------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic r_last;

    // Under contention the port that was not granted last time wins.
    always_comb begin
        if (r0_valid && r1_valid) begin
            w_pick1 = ~r_last;
        end else begin
            w_pick1 = r1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_pick1;
        end
    end
`else
    assign w_pick1 = r1_valid & ~r0_valid;
`endif

    assign w_rsp_take = r_gnt ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        w_sel_op = r0_op;
        w_sel_a  = r0_a;
        w_sel_b  = r0_b;
        if (w_pick1) begin
            w_sel_op = r1_op;
            w_sel_a  = r1_a;
            w_sel_b  = r1_b;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        w_accept     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        busy         = 1'b0;

        case (r_state)
            S_IDLE: begin
                r0_ready = r0_valid & ~w_pick1;
                r1_ready = r1_valid &  w_pick1;
                w_accept = (r0_valid & ~w_pick1) | (r1_valid & w_pick1);
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                busy        = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                busy         = 1'b1;
                r0_rsp_valid = ~r_gnt;
                r1_rsp_valid =  r_gnt;
                // No acceptance in this cycle: the return goes through IDLE.
                if (w_rsp_take) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, operand and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= 1'b0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_gnt <= w_pick1;
            r_op  <= w_sel_op;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_data <= alu_out;
            r_rsp_zero <= alu_zero;
        end
    end

    assign alu_op   = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_data = r_rsp_data;
    assign rsp_zero = r_rsp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a behavioural ALU,
//                directed vectors, corner sequences and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic             r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [OPW-1:0]   r0_op, r1_op, alu_op;
    logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [WIDTH-1:0] rsp_data, alu_a, alu_b, alu_out;
    logic             rsp_zero, busy, alu_zero;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a << b[3:0];
            4'd4:    return a | b;
            4'd5:    return a >> b[3:0];
            4'd6:    return a ^ b;
            4'd7:    return (a < b) ? 16'd1 : 16'd0;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_out == '0);
    end

    // Expected arbitration winner from the pending set, by the arbitration rule.
    function automatic int exp_winner(input bit p0, input bit p1);
        if (p0 && p1) begin
`ifdef ALU_ARB_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        return p1 ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int port, input logic [OPW-1:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (port == 0) begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end
    endtask

    task automatic drop_req(input int port);
        if (port == 0) r0_valid = 1'b0;
        else           r1_valid = 1'b0;
    endtask

    // Called just after a negedge with the request driven; returns after the accepting posedge.
    task automatic wait_accept(input int port, input string name);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port == 0 && r0_ready) || (port == 1 && r1_ready)) begin
                @(posedge clk);
                m_last = port;
                return;
            end
            @(negedge clk);
        end
        check({name, " accept timeout"}, 0, 1);
    endtask

    task automatic single_op(input int port, input logic [OPW-1:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp_d, input logic exp_z,
                             input string name);
        @(negedge clk);
        drive_req(port, op, a, b);
        wait_accept(port, name);
        @(negedge clk);
        drop_req(port);
        check({name, " exec rsp_valid"}, {r1_rsp_valid, r0_rsp_valid}, 0);
        check({name, " exec busy"}, busy, 1);
        @(negedge clk);
        check({name, " rsp_valid"}, {r1_rsp_valid, r0_rsp_valid}, (port == 0) ? 2'b01 : 2'b10);
        check({name, " rsp_data"}, rsp_data, exp_d);
        check({name, " rsp_zero"}, rsp_zero, exp_z);
        check({name, " readies in resp"}, {r1_ready, r0_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        check({name, " back to idle"}, busy, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
    endtask

    typedef struct {
        int               port;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             z;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               pend [2];
        logic [OPW-1:0]   pop  [2];
        logic [WIDTH-1:0] pa   [2];
        logic [WIDTH-1:0] pb   [2];
        logic [WIDTH-1:0] exp_d;
        int               w;

        vecs[0] = '{0, 4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0};
        vecs[1] = '{1, 4'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1};
        vecs[2] = '{0, 4'd2, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0};
        vecs[3] = '{1, 4'd4, 16'h00F0, 16'h000F, 16'h00FF, 1'b0};
        vecs[4] = '{0, 4'd6, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};
        vecs[5] = '{1, 4'd7, 16'h0001, 16'h0002, 16'h0001, 1'b0};
        vecs[6] = '{0, 4'hF, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};

        rst_n = 1'b0;
        r0_valid = 0; r1_valid = 0;
        r0_op = '0; r1_op = '0; r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        m_last = 1;
        #1;
        check("reset busy", busy, 0);
        check("reset rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 0);
        check("reset ready", {r1_ready, r0_ready}, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_zero", rsp_zero, 0);
        check("reset alu inputs", {alu_op, alu_a, alu_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle no request readies", {r1_ready, r0_ready}, 0);

        for (int i = 0; i < 7; i++) begin
            single_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].d, vecs[i].z, $sformatf("vec%0d", i));
        end

        // Contention: both held for 5 operations, then r0 withdraws.
        apply_reset();
        drive_req(0, 4'd2, 16'h00FF, 16'h0F0F);
        drive_req(1, 4'd4, 16'h00F0, 16'h000F);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) drop_req(0);
            w = exp_winner(r0_valid, 1'b1);
            #1;
            check($sformatf("contend%0d grant", k), {r1_ready, r0_ready}, (w == 0) ? 2'b01 : 2'b10);
            @(posedge clk);
            m_last = w;
            @(negedge clk);
            @(negedge clk);
            check($sformatf("contend%0d rsp_valid", k), {r1_rsp_valid, r0_rsp_valid},
                  (w == 0) ? 2'b01 : 2'b10);
            check($sformatf("contend%0d data", k), rsp_data, (w == 0) ? 16'h000F : 16'h00FF);
            @(posedge clk);
            @(negedge clk);
        end
        drop_req(1);

        // Backpressure on r0 while r1 waits.
        r0_rsp_ready = 1'b0;
        drive_req(0, 4'd6, 16'hAAAA, 16'hFFFF);
        wait_accept(0, "bp");
        @(negedge clk);
        drop_req(0);
        drive_req(1, 4'd0, 16'h0001, 16'h0001);
        r1_rsp_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp hold%0d valid", c), {r1_rsp_valid, r0_rsp_valid}, 2'b01);
            check($sformatf("bp hold%0d data", c), rsp_data, 16'h5555);
            check($sformatf("bp hold%0d readies", c), {r1_ready, r0_ready}, 0);
            @(negedge clk);
        end
        r0_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp released idle", {busy, r0_rsp_valid}, 0);
        check("bp released r1 ready", r1_ready, 1);
        drop_req(1);

        // Reset during EXEC.
        @(negedge clk);
        drive_req(0, 4'd1, 16'h00AA, 16'h0001);
        wait_accept(0, "rst");
        @(negedge clk);
        drop_req(0);
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset rsp_data", {rsp_zero, rsp_data}, 0);
        check("midreset alu inputs", {alu_op, alu_a, alu_b}, 0);
        check("midreset rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        check("post reset no response", {r1_rsp_valid, r0_rsp_valid, busy}, 0);
        rst_n = 1'b1;
        m_last = 1;
        single_op(0, 4'd7, 16'h0001, 16'h0002, 16'h0001, 1'b0, "after reset");

        // Randomized traffic with pending requests and random backpressure.
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    pend[p] = 1;
                    pop[p]  = 4'($urandom_range(0, 15));
                    pa[p]   = 16'($urandom);
                    pb[p]   = ($urandom_range(0, 3) == 0) ? pa[p] : 16'($urandom);
                    drive_req(p, pop[p], pa[p], pb[p]);
                end
            end
            #1;
            if (!pend[0] && !pend[1]) begin
                check($sformatf("rnd%0d idle readies", it), {r1_ready, r0_ready}, 0);
                continue;
            end
            w = exp_winner(pend[0], pend[1]);
            check($sformatf("rnd%0d grant", it), {r1_ready, r0_ready}, (w == 0) ? 2'b01 : 2'b10);
            exp_d = alu_f(pop[w], pa[w], pb[w]);
            @(posedge clk);
            m_last = w;
            pend[w] = 0;
            @(negedge clk);
            drop_req(w);
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                check($sformatf("rnd%0d valid", it), {r1_rsp_valid, r0_rsp_valid},
                      (w == 0) ? 2'b01 : 2'b10);
                check($sformatf("rnd%0d data", it), {rsp_zero, rsp_data}, {(exp_d == 0), exp_d});
                check($sformatf("rnd%0d readies", it), {r1_ready, r0_ready}, 0);
                r0_rsp_ready = 1'($urandom_range(0, 1));
                r1_rsp_ready = 1'($urandom_range(0, 1));
                if (c == 5) begin
                    if (w == 0) r0_rsp_ready = 1'b1;
                    else        r1_rsp_ready = 1'b1;
                end
                if ((w == 0 && r0_rsp_ready) || (w == 1 && r1_rsp_ready)) begin
                    @(posedge clk);
                    break;
                end
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
